packetizer_sequencer: RTL and testbench

AXI4-Lite manager that sequences one acquisition on the ADC packetizer: it arms the packetizer by writing the samples-per-packet value to its configuration register, counts completed packets on the packetizer's `last`/`ready` outputs, then disarms it by writing zero. It sits beside the packetizer and drives its AXI4-Lite configuration subordinate. The block replaces software register pokes, so a fixed number of DMA packets is captured from a single `start` pulse.

---
 rtl/packetizer_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_packetizer_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packetizer_sequencer.sv
// AXI4-Lite manager: arms the packetizer with packet_len, counts pkt_last beats, disarms with 0.
// Latency: start -> awvalid/wvalid next cycle; last counted beat -> disarm request next cycle.
// Backpressure: waits indefinitely on awready/wready/bvalid; PACKETIZER_SEQ_READBACK_EN adds a read-back verify.
module packetizer_sequencer #(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] packet_len,
    input  logic [15:0] packet_count,
    input  logic        pkt_last,
    input  logic        pkt_ready,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] packets_done,
    output logic [31:0] m_axi_lite_awaddr,
    output logic [2:0]  m_axi_lite_awprot,
    output logic        m_axi_lite_awvalid,
    input  logic        m_axi_lite_awready,
    output logic [31:0] m_axi_lite_wdata,
    output logic [3:0]  m_axi_lite_wstrb,
    output logic        m_axi_lite_wvalid,
    input  logic        m_axi_lite_wready,
    input  logic [1:0]  m_axi_lite_bresp,
    input  logic        m_axi_lite_bvalid,
    output logic        m_axi_lite_bready
`ifdef PACKETIZER_SEQ_READBACK_EN
    ,
    output logic [31:0] m_axi_lite_araddr,
    output logic [2:0]  m_axi_lite_arprot,
    output logic        m_axi_lite_arvalid,
    input  logic        m_axi_lite_arready,
    input  logic [31:0] m_axi_lite_rdata,
    input  logic [1:0]  m_axi_lite_rresp,
    input  logic        m_axi_lite_rvalid,
    output logic        m_axi_lite_rready
`endif
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ARM_REQ,
        S_ARM_RESP,
`ifdef PACKETIZER_SEQ_READBACK_EN
        S_VERIFY_AR,
        S_VERIFY_R,
`endif
        S_RUN,
        S_DISARM_REQ,
        S_DISARM_RESP,
        S_DONE
    } state_t;

    localparam logic [31:0] CFG_ADDR = ADDR_BASE + 32'h200;

    state_t      state;
    logic [31:0] len_q;
    logic [15:0] count_q;
    logic        abort_q;
    logic        beat;
    logic [15:0] pkt_inc;
    logic        aw_ok;
    logic        w_ok;

    assign m_axi_lite_awaddr = CFG_ADDR;
    assign m_axi_lite_awprot = 3'b000;
    assign m_axi_lite_wstrb  = 4'hF;
`ifdef PACKETIZER_SEQ_READBACK_EN
    assign m_axi_lite_araddr = CFG_ADDR;
    assign m_axi_lite_arprot = 3'b000;
`endif

    assign beat    = pkt_last & pkt_ready;
    assign pkt_inc = packets_done + 16'd1;
    // A channel counts as complete once its valid has dropped or is handshaking now.
    assign aw_ok   = !m_axi_lite_awvalid || m_axi_lite_awready;
    assign w_ok    = !m_axi_lite_wvalid  || m_axi_lite_wready;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state              <= S_IDLE;
            len_q              <= 32'd0;
            count_q            <= 16'd0;
            abort_q            <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b0;
            error              <= 1'b0;
            packets_done       <= 16'd0;
            m_axi_lite_awvalid <= 1'b0;
            m_axi_lite_wvalid  <= 1'b0;
            m_axi_lite_wdata   <= 32'd0;
            m_axi_lite_bready  <= 1'b0;
`ifdef PACKETIZER_SEQ_READBACK_EN
            m_axi_lite_arvalid <= 1'b0;
            m_axi_lite_rready  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (busy && state != S_RUN && abort)
                abort_q <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        len_q        <= packet_len;
                        count_q      <= packet_count;
                        error        <= 1'b0;
                        packets_done <= 16'd0;
                        abort_q      <= 1'b0;
                        if (packet_len == 32'd0 || packet_count == 16'd0) begin
                            error <= 1'b1;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            busy               <= 1'b1;
                            m_axi_lite_awvalid <= 1'b1;
                            m_axi_lite_wvalid  <= 1'b1;
                            m_axi_lite_wdata   <= packet_len;
                            state              <= S_ARM_REQ;
                        end
                    end
                end

                S_ARM_REQ, S_DISARM_REQ: begin
                    if (m_axi_lite_awvalid && m_axi_lite_awready)
                        m_axi_lite_awvalid <= 1'b0;
                    if (m_axi_lite_wvalid && m_axi_lite_wready)
                        m_axi_lite_wvalid <= 1'b0;
                    if (aw_ok && w_ok) begin
                        m_axi_lite_bready <= 1'b1;
                        state <= (state == S_ARM_REQ) ? S_ARM_RESP : S_DISARM_RESP;
                    end
                end

                S_ARM_RESP: begin
                    if (m_axi_lite_bvalid) begin
                        m_axi_lite_bready <= 1'b0;
                        if (m_axi_lite_bresp != 2'b00) begin
                            // Arm write failed: the packetizer was never armed, so skip the disarm.
                            error <= 1'b1;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
`ifdef PACKETIZER_SEQ_READBACK_EN
                            m_axi_lite_arvalid <= 1'b1;
                            state              <= S_VERIFY_AR;
`else
                            state <= S_RUN;
`endif
                        end
                    end
                end

`ifdef PACKETIZER_SEQ_READBACK_EN
                S_VERIFY_AR: begin
                    if (m_axi_lite_arready) begin
                        m_axi_lite_arvalid <= 1'b0;
                        m_axi_lite_rready  <= 1'b1;
                        state              <= S_VERIFY_R;
                    end
                end

                S_VERIFY_R: begin
                    if (m_axi_lite_rvalid) begin
                        m_axi_lite_rready <= 1'b0;
                        if (m_axi_lite_rresp != 2'b00 || m_axi_lite_rdata != len_q) begin
                            error              <= 1'b1;
                            m_axi_lite_awvalid <= 1'b1;
                            m_axi_lite_wvalid  <= 1'b1;
                            m_axi_lite_wdata   <= 32'd0;
                            state              <= S_DISARM_REQ;
                        end else begin
                            state <= S_RUN;
                        end
                    end
                end
`endif

                S_RUN: begin
                    if (beat)
                        packets_done <= pkt_inc;
                    if ((beat && pkt_inc == count_q) || abort || abort_q) begin
                        m_axi_lite_awvalid <= 1'b1;
                        m_axi_lite_wvalid  <= 1'b1;
                        m_axi_lite_wdata   <= 32'd0;
                        state              <= S_DISARM_REQ;
                    end
                end

                S_DISARM_RESP: begin
                    if (m_axi_lite_bvalid) begin
                        m_axi_lite_bready <= 1'b0;
                        if (m_axi_lite_bresp != 2'b00)
                            error <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end

                S_DONE: state <= S_IDLE;

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_packetizer_sequencer.sv
// Directed bench for packetizer_sequencer with a small AXI4-Lite subordinate responder.
module tb_packetizer_sequencer;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] packet_len = 32'd0;
    logic [15:0] packet_count = 16'd0;
    logic        pkt_last = 1'b0;
    logic        pkt_ready = 1'b0;
    logic        busy, done, error;
    logic [15:0] packets_done;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready = 1'b0;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready = 1'b0;
    logic [1:0]  bresp = 2'b00;
    logic        bvalid = 1'b0;
    logic        bready;
`ifdef PACKETIZER_SEQ_READBACK_EN
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata = 32'd0;
    logic [1:0]  rresp = 2'b00;
    logic        rvalid = 1'b0;
    logic        rready;
    logic        rb_bad = 1'b0;
`endif

    packetizer_sequencer dut (
        .aclk(aclk), .areset(areset), .start(start), .abort(abort),
        .packet_len(packet_len), .packet_count(packet_count),
        .pkt_last(pkt_last), .pkt_ready(pkt_ready),
        .busy(busy), .done(done), .error(error), .packets_done(packets_done),
        .m_axi_lite_awaddr(awaddr), .m_axi_lite_awprot(awprot),
        .m_axi_lite_awvalid(awvalid), .m_axi_lite_awready(awready),
        .m_axi_lite_wdata(wdata), .m_axi_lite_wstrb(wstrb),
        .m_axi_lite_wvalid(wvalid), .m_axi_lite_wready(wready),
        .m_axi_lite_bresp(bresp), .m_axi_lite_bvalid(bvalid), .m_axi_lite_bready(bready)
`ifdef PACKETIZER_SEQ_READBACK_EN
        ,
        .m_axi_lite_araddr(araddr), .m_axi_lite_arprot(arprot),
        .m_axi_lite_arvalid(arvalid), .m_axi_lite_arready(arready),
        .m_axi_lite_rdata(rdata), .m_axi_lite_rresp(rresp),
        .m_axi_lite_rvalid(rvalid), .m_axi_lite_rready(rready)
`endif
    );

    always #5 aclk = ~aclk;

    int          checks = 0;
    int          passed = 0;
    int          aw_stall = 0;
    int          w_stall = 0;
    int          aw_wc = 0;
    int          w_wc = 0;
    int          aw_hs = 0;
    int          done_cnt = 0;
    logic [1:0]  arm_bresp = 2'b00;
    logic [1:0]  disarm_bresp = 2'b00;
    logic [31:0] last_w = 32'd0;
    logic [31:0] aw_addr_last = 32'd0;
    logic [31:0] wr_data[$];

    // Subordinate: ready after a programmable stall, response one cycle after bready.
    always @(negedge aclk) begin
        if (awvalid) begin
            awready = (aw_wc >= aw_stall);
            aw_wc++;
        end else begin
            awready = 1'b0;
            aw_wc = 0;
        end
        if (wvalid) begin
            wready = (w_wc >= w_stall);
            w_wc++;
        end else begin
            wready = 1'b0;
            w_wc = 0;
        end
        bvalid = bready;
        bresp  = bready ? ((last_w != 32'd0) ? arm_bresp : disarm_bresp) : 2'b00;
`ifdef PACKETIZER_SEQ_READBACK_EN
        arready = arvalid;
        rvalid  = rready;
        rdata   = rb_bad ? last_w - 32'd1 : last_w;
        rresp   = 2'b00;
`endif
    end

    always @(posedge aclk) begin
        if (awvalid && awready) begin
            aw_hs++;
            aw_addr_last = awaddr;
        end
        if (wvalid && wready) begin
            wr_data.push_back(wdata);
            last_w = wdata;
        end
        if (done)
            done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_start(input logic [31:0] len, input logic [15:0] cnt);
        packet_len   = len;
        packet_count = cnt;
        start        = 1'b1;
        @(negedge aclk);
        start = 1'b0;
    endtask

    // Returns at the first negedge spent in RUN.
    task automatic wait_run();
        logic got;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
`ifdef PACKETIZER_SEQ_READBACK_EN
            if (rready) begin got = 1'b1; break; end
`else
            if (bready) begin got = 1'b1; break; end
`endif
            @(negedge aclk);
        end
        chk("run_reached", 32'(got), 32'd1);
        @(negedge aclk);
    endtask

    task automatic wait_done();
        logic got;
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (done) begin got = 1'b1; break; end
            @(negedge aclk);
        end
        chk("done_reached", 32'(got), 32'd1);
    endtask

    task automatic pulse_beat();
        pkt_last  = 1'b1;
        pkt_ready = 1'b1;
        @(negedge aclk);
        pkt_last  = 1'b0;
        pkt_ready = 1'b0;
    endtask

    initial begin
        int wr0, dc0;

        // Reset state
        repeat (3) @(negedge aclk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_packets_done", 32'(packets_done), 32'd0);
        chk("rst_awvalid", 32'(awvalid), 32'd0);
        chk("rst_wvalid", 32'(wvalid), 32'd0);
        chk("rst_bready", 32'(bready), 32'd0);
        areset = 1'b0;
        @(negedge aclk);

        // Normal sequence: len 16, 3 packets
        dc0 = done_cnt;
        do_start(32'd16, 16'd3);
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_awvalid", 32'(awvalid), 32'd1);
        chk("start_wvalid", 32'(wvalid), 32'd1);
        chk("awaddr", awaddr, 32'h200);
        chk("awprot", 32'(awprot), 32'd0);
        chk("wstrb", 32'(wstrb), 32'hF);
        wait_run();
        pkt_last = 1'b1;
        pkt_ready = 1'b1;
        repeat (3) @(negedge aclk);
        pkt_last = 1'b0;
        pkt_ready = 1'b0;
        chk("stop_packets_done", 32'(packets_done), 32'd3);
        chk("stop_awvalid", 32'(awvalid), 32'd1);
        wait_done();
        chk("norm_error", 32'(error), 32'd0);
        chk("norm_busy_at_done", 32'(busy), 32'd0);
        chk("norm_wr_count", 32'(wr_data.size()), 32'd2);
        chk("norm_wr_arm", wr_data[0], 32'd16);
        chk("norm_wr_disarm", wr_data[1], 32'd0);
        chk("norm_aw_addr", aw_addr_last, 32'h200);
        @(negedge aclk);
        chk("norm_done_pulse", 32'(done), 32'd0);
        chk("norm_done_count", 32'(done_cnt - dc0), 32'd1);
        chk("norm_hold_packets", 32'(packets_done), 32'd3);

        // Zero configuration
        wr0 = wr_data.size();
        do_start(32'd16, 16'd0);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_error", 32'(error), 32'd1);
        chk("zero_busy", 32'(busy), 32'd0);
        chk("zero_awvalid", 32'(awvalid), 32'd0);
        chk("zero_packets_cleared", 32'(packets_done), 32'd0);
        @(negedge aclk);
        chk("zero_done_drop", 32'(done), 32'd0);
        chk("zero_no_writes", 32'(wr_data.size() - wr0), 32'd0);
        chk("zero_error_hold", 32'(error), 32'd1);

        // Stalled AW, beats outside RUN ignored
        aw_stall = 5;
        pkt_last = 1'b1;
        pkt_ready = 1'b1;
        do_start(32'd8, 16'd1);
        chk("stall_error_cleared", 32'(error), 32'd0);
        @(negedge aclk);
        chk("stall_wvalid_drop", 32'(wvalid), 32'd0);
        chk("stall_awvalid_hold", 32'(awvalid), 32'd1);
        begin
            int k;
            k = 2;
            while (!bready && k < 30) begin
                @(negedge aclk);
                k++;
            end
            chk("stall_resp_cycle", 32'(k), 32'd7);
        end
        pkt_last = 1'b0;
        pkt_ready = 1'b0;
        aw_stall = 0;
        chk("stall_no_early_count", 32'(packets_done), 32'd0);
        @(negedge aclk);
        pulse_beat();
        wait_done();
        chk("stall_packets", 32'(packets_done), 32'd1);
        chk("stall_error", 32'(error), 32'd0);
        @(negedge aclk);

        // Arm write error: no disarm
        arm_bresp = 2'b10;
        wr0 = wr_data.size();
        do_start(32'd4, 16'd2);
        wait_done();
        chk("armerr_error", 32'(error), 32'd1);
        chk("armerr_writes", 32'(wr_data.size() - wr0), 32'd1);
        arm_bresp = 2'b00;
        @(negedge aclk);

        // Disarm write error
        disarm_bresp = 2'b10;
        wr0 = wr_data.size();
        do_start(32'd4, 16'd1);
        chk("diserr_error_cleared", 32'(error), 32'd0);
        wait_run();
        pulse_beat();
        wait_done();
        chk("diserr_error", 32'(error), 32'd1);
        chk("diserr_packets", 32'(packets_done), 32'd1);
        chk("diserr_writes", 32'(wr_data.size() - wr0), 32'd2);
        disarm_bresp = 2'b00;
        @(negedge aclk);

        // Abort during ARM_REQ
        aw_stall = 3;
        wr0 = wr_data.size();
        do_start(32'd16, 16'd4);
        abort = 1'b1;
        @(negedge aclk);
        abort = 1'b0;
        wait_done();
        aw_stall = 0;
        chk("abort_arm_packets", 32'(packets_done), 32'd0);
        chk("abort_arm_writes", 32'(wr_data.size() - wr0), 32'd2);
        chk("abort_arm_last_wr", last_w, 32'd0);
        chk("abort_arm_error", 32'(error), 32'd0);
        @(negedge aclk);

        // Abort after one of four packets, with a start pulse while busy
        wr0 = wr_data.size();
        dc0 = done_cnt;
        do_start(32'd16, 16'd4);
        wait_run();
        pulse_beat();
        do_start(32'd99, 16'd0);
        chk("busy_start_ignored", 32'(error), 32'd0);
        abort = 1'b1;
        @(negedge aclk);
        abort = 1'b0;
        wait_done();
        chk("abort_run_packets", 32'(packets_done), 32'd1);
        chk("abort_run_writes", 32'(wr_data.size() - wr0), 32'd2);
        chk("abort_run_error", 32'(error), 32'd0);
        @(negedge aclk);
        chk("abort_run_done_count", 32'(done_cnt - dc0), 32'd1);

`ifdef PACKETIZER_SEQ_READBACK_EN
        // Readback mismatch: error, disarm still issued
        rb_bad = 1'b1;
        wr0 = wr_data.size();
        do_start(32'd16, 16'd2);
        wait_done();
        chk("rb_error", 32'(error), 32'd1);
        chk("rb_writes", 32'(wr_data.size() - wr0), 32'd2);
        chk("rb_last_wr", last_w, 32'd0);
        rb_bad = 1'b0;
        @(negedge aclk);
`endif

        // Asynchronous reset drops valids immediately
        aw_stall = 10;
        do_start(32'd16, 16'd2);
        chk("pre_rst_awvalid", 32'(awvalid), 32'd1);
        #2 areset = 1'b1;
        #1;
        chk("async_rst_awvalid", 32'(awvalid), 32'd0);
        chk("async_rst_wvalid", 32'(wvalid), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
